// File: rtl/des_perm_pkg.sv
// Shared DES permutation tables, mode encodings and the table-driven permute helper.
// Bit numbering follows DES: table entry k names source bit k, bit 1 being the MSB.
package des_perm_pkg;

  localparam logic MODE_IP = 1'b0;
  localparam logic MODE_FP = 1'b1;

  typedef logic [6:0] perm_table_t [64];

  localparam perm_table_t IP_TABLE = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam perm_table_t FP_TABLE = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  // DES bit k lives at vector index 64-k, so out bit i+1 sits at index 63-i.
  function automatic logic [63:0] permute(input logic [63:0] data, input perm_table_t tbl);
    logic [63:0] res;
    logic [5:0]  src_idx;
    logic [5:0]  dst_idx;
    res = 64'd0;
    for (int i = 32'sd0; i < 32'sd64; i++) begin
      src_idx      = 6'(7'd64 - tbl[i]);
      dst_idx      = 6'(32'sd63 - i);
      res[dst_idx] = data[src_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_pipe_stage.sv
// One valid/ready register slice; the parent decides when the slot may be refilled.
module des_pipe_stage #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Slot register: a bubble only clears valid, so held payload stays quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= up_data;
      end
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/des_perm_pipe.sv
// DES IP/FP permutation followed by a STAGES-deep valid/ready register pipeline.
// Optional macro DES_PERM_SWAP_EN swaps the 32-bit halves ahead of FP (mode 1 only).
module des_perm_pipe
  import des_perm_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [63:0]                   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_mode,
  output logic [TAG_W-1:0]              out_tag,
  output logic [63:0]                   out_data,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int PW = 1 + TAG_W + 64;
  localparam int CW = $clog2(STAGES + 1);
  localparam logic [STAGES-1:0] FULL_MASK = {STAGES{1'b1}};

  logic [63:0]       pre_s;
  logic [63:0]       perm_s;
  logic [PW-1:0]     in_payload_s;
  logic [STAGES-1:0] stage_valid_s;
  logic [PW-1:0]     stage_data_s [STAGES];
  logic [STAGES-1:0] ready_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic [CW-1:0]     count_r;

  // Input-side permutation, optionally preceded by the final L16/R16 swap
  always_comb begin
`ifdef DES_PERM_SWAP_EN
    if (in_mode == MODE_FP) begin
      pre_s = {in_data[31:0], in_data[63:32]};
    end else begin
      pre_s = in_data;
    end
`else
    pre_s = in_data;
`endif
    if (in_mode == MODE_IP) begin
      perm_s = permute(pre_s, IP_TABLE);
    end else begin
      perm_s = permute(pre_s, FP_TABLE);
    end
  end

  assign in_payload_s = {in_mode, in_tag, perm_s};

  // Stage g may load unless it and every stage after it are full while the sink stalls.
  // Deriving this from the registered valids avoids a combinational ready chain.
  for (genvar g = 0; g < STAGES; g++) begin : gen_stage
    localparam logic [STAGES-1:0] LOW_MASK = FULL_MASK >> (STAGES - g);

    assign ready_s[g] = out_ready || ((stage_valid_s | LOW_MASK) != FULL_MASK);

    if (g == 0) begin : gen_first
      des_pipe_stage #(.W(PW)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (ready_s[g]),
        .up_valid (in_valid),
        .up_data  (in_payload_s),
        .valid    (stage_valid_s[g]),
        .data     (stage_data_s[g])
      );
    end else begin : gen_next
      des_pipe_stage #(.W(PW)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (ready_s[g]),
        .up_valid (stage_valid_s[g-1]),
        .up_data  (stage_data_s[g-1]),
        .valid    (stage_valid_s[g]),
        .data     (stage_data_s[g])
      );
    end
  end

  assign in_ready   = ready_s[0];
  assign in_xfer_s  = in_valid && ready_s[0];
  assign out_valid  = stage_valid_s[STAGES-1];
  assign out_xfer_s = out_valid && out_ready;
  assign {out_mode, out_tag, out_data} = stage_data_s[STAGES-1];

  // Occupancy counter: simultaneous accept and emit leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (in_xfer_s && !out_xfer_s) begin
      count_r <= count_r + CW'(1'b1);
    end else if (!in_xfer_s && out_xfer_s) begin
      count_r <= count_r - CW'(1'b1);
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed self-checking bench for des_perm_pipe: vector table plus stall, streaming,
// random round-trip and mid-flight reset sequences.
module tb_des_perm_pipe;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic [63:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [TAG_W-1:0]  out_tag;
  logic [63:0]       out_data;
  logic [1:0]        count;

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } obs_t;

  typedef struct {
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic [63:0]      din;
    logic [63:0]      dout;
  } vec_t;

  obs_t mon_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Record every output handshake (evaluated mid-cycle, completes at the next rising edge)
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_q.push_back({out_mode, out_tag, out_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] swap_if(input logic [63:0] x);
`ifdef DES_PERM_SWAP_EN
    return {x[31:0], x[63:32]};
`else
    return x;
`endif
  endfunction

  // Present one block and hold it until accepted; call just after a rising edge
  task automatic push(input logic m, input logic [TAG_W-1:0] t, input logic [63:0] d);
    int guard;
    logic ok;
    guard = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_tag   = t;
    in_data  = d;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 64'(guard), 64'd0);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while (count != 2'd0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (count != 2'd0) check("drain_timeout", 64'(count), 64'd0);
  endtask

  vec_t        vecs [10];
  logic [63:0] orig [1000];
  int          lat, mark, mark2, acc, errs, bubbles, bad_cnt, rdy_err;
  obs_t        exp_q [$];
  obs_t        ob;

  initial begin
    vecs[0] = '{1'b0, 4'h1, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA};
    vecs[1] = '{1'b1, 4'h2, swap_if(64'hCC00CCFFF0AAF0AA), 64'h0123456789ABCDEF};
    vecs[2] = '{1'b0, 4'h3, 64'h0000000000000000, 64'h0000000000000000};
    vecs[3] = '{1'b0, 4'h4, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{1'b0, 4'h5, 64'h0000000000000040, 64'h8000000000000000};
    vecs[5] = '{1'b0, 4'h6, 64'h8000000000000000, 64'h0000000001000000};
    vecs[6] = '{1'b1, 4'h7, swap_if(64'h0000000001000000), 64'h8000000000000000};
    vecs[7] = '{1'b1, 4'h8, swap_if(64'h8000000000000000), 64'h0000000000000040};
    vecs[8] = '{1'b0, 4'h9, 64'hAAAAAAAAAAAAAAAA, 64'h00000000FFFFFFFF};
    vecs[9] = '{1'b1, 4'hA, swap_if(64'h00000000FFFFFFFF), 64'hAAAAAAAAAAAAAAAA};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_bits", {59'd0, out_mode, out_tag}, 64'd0);
    check("reset_out_data", out_data, 64'd0);

    // Table: single blocks, latency and permutation result
    out_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      @(posedge clk);
      #1;
      push(vecs[v].mode, vecs[v].tag, vecs[v].din);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
        lat++;
        @(negedge clk);
      end
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(STAGES));
      check($sformatf("vec%0d_data", v), out_data, vecs[v].dout);
      check($sformatf("vec%0d_mode", v), 64'(out_mode), 64'(vecs[v].mode));
      check($sformatf("vec%0d_tag", v), 64'(out_tag), 64'(vecs[v].tag));
    end
    wait_drain();

    // Backpressure: fill while the sink stalls, then release
    @(posedge clk);
    #1;
    out_ready = 1'b0; acc = 0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 64'h0123456789ABCDEF; in_tag = 4'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      in_tag = 4'(acc);
    end
    @(negedge clk);
    check("bp_accepts", 64'(acc), 64'(STAGES));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_count", 64'(count), 64'(STAGES));
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_tag", 64'(out_tag), 64'd0);
      check("bp_hold_data", out_data, 64'hCC00CCFFF0AAF0AA);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      check("bp_release_valid", 64'(out_valid), 64'd1);
      check("bp_release_tag", 64'(out_tag), 64'(k));
      @(negedge clk);
    end
    wait_drain();

    // Streaming: 64 back-to-back blocks with alternating modes
    @(posedge clk);
    #1;
    out_ready = 1'b1; bubbles = 0; bad_cnt = 0; rdy_err = 0;
    mark = mon_q.size();
    exp_q = {};
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'(k % 2);
      in_tag   = 4'(k);
      in_data  = (k % 2 == 1) ? swap_if(64'hCC00CCFFF0AAF0AA) : 64'h0123456789ABCDEF;
      exp_q.push_back({1'(k % 2), 4'(k),
                       (k % 2 == 1) ? 64'h0123456789ABCDEF : 64'hCC00CCFFF0AAF0AA});
      @(negedge clk);
      if (!in_ready) rdy_err++;
      if (k >= STAGES) begin
        if (!out_valid) bubbles++;
        if (count != 2'(STAGES)) bad_cnt++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("stream_in_ready_drops", 64'(rdy_err), 64'd0);
    check("stream_bubbles", 64'(bubbles), 64'd0);
    check("stream_count_steady", 64'(bad_cnt), 64'd0);
    check("stream_out_count", 64'(mon_q.size() - mark), 64'd64);
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (mark + k < mon_q.size()) begin
        if (mon_q[mark + k] !== exp_q[k]) errs++;
      end else begin
        errs++;
      end
    end
    check("stream_order_data", 64'(errs), 64'd0);

    // Random round trip: IP then FP must restore every block
    @(posedge clk);
    #1;
    mark = mon_q.size();
    for (int i = 0; i < 1000; i++) begin
      orig[i] = {$urandom(), $urandom()};
      push(1'b0, 4'(i), orig[i]);
    end
    wait_drain();
    check("rand_ip_count", 64'(mon_q.size() - mark), 64'd1000);
    @(posedge clk);
    #1;
    mark2 = mon_q.size();
    for (int i = 0; i < 1000; i++) begin
      ob = (mark + i < mark2) ? mon_q[mark + i] : '0;
      push(1'b1, 4'(i), swap_if(ob.data));
    end
    wait_drain();
    check("rand_fp_count", 64'(mon_q.size() - mark2), 64'd1000);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (mark2 + i < mon_q.size()) begin
        ob = mon_q[mark2 + i];
        if (ob.data !== orig[i] || ob.tag !== 4'(i) || ob.mode !== 1'b1) errs++;
      end else begin
        errs++;
      end
    end
    check("rand_identity_errs", 64'(errs), 64'd0);

    // Reset with two blocks in flight: they must vanish
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(1'b0, 4'hE, 64'h0123456789ABCDEF);
    push(1'b1, 4'hF, 64'h0123456789ABCDEF);
    @(negedge clk);
    check("rst_pre_count", 64'(count), 64'd2);
    mark = mon_q.size();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_output", 64'(mon_q.size() - mark), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
